btn_led_ctrl: RTL and testbench

// Clocked controller for the switch/button/LED datapath. Removes the raw button as a clock.

---
 rtl/btn_led_ctrl.sv | 131 +++++++++++++
 tb/tb_btn_led_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/btn_led_ctrl.sv
// Button/switch/LED controller: synchronises the raw pins, debounces the button
// with a counter FSM, captures sw1&sw2 on each clean press and optionally blinks the LED.
module btn_led_ctrl #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int BLINK_HALF_PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw1,
  input  logic sw2,
  input  logic btn,
  input  logic blink_en,
  output logic led_out,
  output logic press_pulse,
  output logic led_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BLINK_HALF_PERIOD);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_HALF_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WAIT_HI, PRESSED, WAIT_LO} state_t;

  logic [SYNC_STAGES-1:0] btn_sync_q, sw1_sync_q, sw2_sync_q;
  logic                   btn_s, sw1_s, sw2_s;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic                   phase_q, phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_q <= '0;
      sw1_sync_q <= '0;
      sw2_sync_q <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn};
      sw1_sync_q <= {sw1_sync_q[SYNC_STAGES-2:0], sw1};
      sw2_sync_q <= {sw2_sync_q[SYNC_STAGES-2:0], sw2};
    end
  end

  assign btn_s = btn_sync_q[SYNC_STAGES-1];
  assign sw1_s = sw1_sync_q[SYNC_STAGES-1];
  assign sw2_s = sw2_sync_q[SYNC_STAGES-1];

  // A level is accepted after DEBOUNCE_CYCLES consecutive equal samples; any
  // opposite sample during the wait falls back to the previous stable state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      press_pulse <= 1'b0;
      led_state   <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= WAIT_HI;
            cnt_q   <= CW'(1);
          end
        end
        WAIT_HI: begin
          if (!btn_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= PRESSED;
            cnt_q       <= '0;
            press_pulse <= 1'b1;
            led_state   <= sw1_s & sw2_s;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_q <= WAIT_LO;
            cnt_q   <= CW'(1);
          end
        end
        WAIT_LO: begin
          if (btn_s) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Blink restarts in the "on" half whenever it is not actively running.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (press_pulse || !led_state || !blink_en) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (bcnt_q == BCNT_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      led_out <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      led_out <= led_state & (blink_en ? phase_q : 1'b1);
    end
  end

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed bench for btn_led_ctrl with small debounce/blink parameters.
module tb_btn_led_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sw1 = 1'b0, sw2 = 1'b0, btn = 1'b0, blink_en = 1'b0;
  logic led_out, press_pulse, led_state;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int p0;

  btn_led_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BLINK_HALF_PERIOD(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw1(sw1), .sw2(sw2), .btn(btn),
    .blink_en(blink_en), .led_out(led_out), .press_pulse(press_pulse),
    .led_state(led_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic btn, sw1, sw2, blink_en;
    logic exp_pulse, exp_state, exp_led;
  } vec_t;

  vec_t tbl[10];
  logic blink_pat[10];

  task automatic step();
    @(posedge clk);
    #1;
    if (press_pulse === 1'b1) pulses++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold_btn(input logic v, input int n);
    btn = v;
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".led_out"}, {31'd0, led_out}, 0);
    check({name, ".press_pulse"}, {31'd0, press_pulse}, 0);
    check({name, ".led_state"}, {31'd0, led_state}, 0);
  endtask

  initial begin
    // Clean press from IDLE: raw edge before edge 1, pulse after edge 6, LED one edge later.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    blink_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // 1. async reset with btn and switches high, checked before any clock edge
    btn = 1'b1; sw1 = 1'b1; sw2 = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    btn = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    check_reset_outputs("post_reset_idle");

    // 2. clean press held 20 cycles
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      btn = tbl[i].btn; sw1 = tbl[i].sw1; sw2 = tbl[i].sw2; blink_en = tbl[i].blink_en;
      step();
      check($sformatf("clean[%0d].pulse", i), {31'd0, press_pulse}, {31'd0, tbl[i].exp_pulse});
      check($sformatf("clean[%0d].state", i), {31'd0, led_state}, {31'd0, tbl[i].exp_state});
      check($sformatf("clean[%0d].led", i), {31'd0, led_out}, {31'd0, tbl[i].exp_led});
    end
    hold_btn(1'b1, 10);
    check("clean.pulse_count", pulses, 1);

    // 3. bounce 1,1,1,0 never accepted; sw2=0 would expose a false capture
    hold_btn(1'b0, 10);
    sw2 = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 16; i++) begin
      btn = (i % 4 != 3);
      step();
    end
    check("bounce.no_pulse", pulses - p0, 0);
    check("bounce.state_kept", {31'd0, led_state}, 1);

    // 4. stable hold after bounce captures sw1=1, sw2=0
    p0 = pulses;
    hold_btn(1'b1, 12);
    check("capture.one_pulse", pulses - p0, 1);
    check("capture.state", {31'd0, led_state}, 0);
    check("capture.led", {31'd0, led_out}, 0);
    hold_btn(1'b0, 10);
    sw2 = 1'b1;
    repeat (8) step();
    check("capture.sw_no_press", {31'd0, led_state}, 0);

    // 5. blink: period 6 starting in the on half; disable forces steady on
    p0 = pulses;
    hold_btn(1'b1, 12);
    check("blink.press", pulses - p0, 1);
    check("blink.state", {31'd0, led_state}, 1);
    check("blink.steady_led", {31'd0, led_out}, 1);
    blink_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("blink[%0d]", i), {31'd0, led_out}, {31'd0, blink_pat[i]});
    end
    blink_en = 1'b0;
    step();
    check("blink.disable_on", {31'd0, led_out}, 1);
    blink_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("blink_restart[%0d]", i), {31'd0, led_out}, {31'd0, blink_pat[i]});
    end
    blink_en = 1'b0;
    step();

    // 6. release with a 2-cycle glitch high, then a recapturing press
    p0 = pulses;
    hold_btn(1'b0, 2);
    hold_btn(1'b1, 2);
    hold_btn(1'b0, 10);
    check("release_glitch.no_pulse", pulses - p0, 0);
    check("release_glitch.state", {31'd0, led_state}, 1);
    sw2 = 1'b0;
    p0 = pulses;
    hold_btn(1'b1, 12);
    check("repress.one_pulse", pulses - p0, 1);
    check("repress.state", {31'd0, led_state}, 0);

    // 7. reset mid-blink, released with btn still held: one press accepted
    hold_btn(1'b0, 10);
    sw2 = 1'b1; blink_en = 1'b1;
    hold_btn(1'b1, 12);
    check("midblink.state_before", {31'd0, led_state}, 1);
    step(); step();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midblink_reset");
    step();
    rst_n = 1'b1;
    p0 = pulses;
    repeat (12) step();
    check("held_after_reset.one_pulse", pulses - p0, 1);
    check("held_after_reset.state", {31'd0, led_state}, 1);

    // 8. reset mid-debounce discards the pending press
    blink_en = 1'b0;
    hold_btn(1'b0, 10);
    hold_btn(1'b1, 3);
    #2 rst_n = 1'b0;
    btn = 1'b0;
    #1 check_reset_outputs("middebounce_reset");
    step();
    rst_n = 1'b1;
    p0 = pulses;
    repeat (10) step();
    check("middebounce.no_pulse", pulses - p0, 0);
    check("middebounce.state", {31'd0, led_state}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
